register_file_8x16: RTL and testbench

REGISTER_FILE_8X16 -- requirements
Module: register_file_8x16

---
 rtl/register_file_8x16.sv | 51 +++++
 tb/tb_register_file_8x16.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/register_file_8x16.sv
// 8 x 16-bit register file: R0 hard-wired to zero, two combinational read ports
// with write-through bypass, one write port gated by a global stall enable.
module register_file_8x16 #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             E,
  input  logic             WE,
  input  logic [2:0]       WA,
  input  logic [WIDTH-1:0] WD,
  input  logic [2:0]       RA1,
  input  logic [2:0]       RA2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic [7:0]       WR_CNT
);

  logic [WIDTH-1:0] r_regs [1:NREG-1];
  logic [7:0]       r_wr_cnt;
  logic [WIDTH-1:0] w_view [NREG];
  logic             w_wr;

  // A qualified write is the only thing that touches state or bypasses reads;
  // WA/WD are never looked at unless WE is high.
  assign w_wr = !RST && E && WE && (WA != 3'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 1; i < NREG; i++) r_regs[i] <= '0;
      r_wr_cnt <= 8'h00;
    end else if (w_wr) begin
      for (int i = 1; i < NREG; i++) begin
        if (WA == 3'(i)) r_regs[i] <= WD;
      end
      r_wr_cnt <= r_wr_cnt + 8'h01;
    end
  end

  always_comb begin
    w_view[0] = '0;
    for (int i = 1; i < NREG; i++) w_view[i] = r_regs[i];
  end

  // Bypass sees only addresses 1..7 because w_wr already excludes WA==0.
  assign RD1    = (w_wr && (RA1 == WA)) ? WD : w_view[RA1];
  assign RD2    = (w_wr && (RA2 == WA)) ? WD : w_view[RA2];
  assign WR_CNT = r_wr_cnt;

endmodule

// File: tb/tb_register_file_8x16.sv
// Directed bench for register_file_8x16: vector table plus hand sequences for
// stall, mid-operation reset and write-counter wrap.
module tb_register_file_8x16;

  logic        CLK = 1'b0;
  logic        RST, E, WE;
  logic [2:0]  WA, RA1, RA2;
  logic [15:0] WD, RD1, RD2;
  logic [7:0]  WR_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  register_file_8x16 dut (
    .CLK(CLK), .RST(RST), .E(E), .WE(WE), .WA(WA), .WD(WD),
    .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2), .WR_CNT(WR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        e;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [15:0] x1;
    logic [15:0] x2;
    logic [7:0]  xc;
  } vec_t;

  vec_t tv [17];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic e, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [2:0] ra1, input logic [2:0] ra2);
    RST = rst; E = e; WE = we; WA = wa; WD = wd; RA1 = ra1; RA2 = ra2;
    #2;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Expected values are checked before the edge that commits the row.
    //        e    we   wa    wd        ra1   ra2   x1        x2        xc
    tv[0]  = '{1'b0,1'b0,3'd0,16'h0000,3'd1,3'd7,16'h0000,16'h0000,8'd0};
    tv[1]  = '{1'b0,1'b0,3'd0,16'h0000,3'd2,3'd6,16'h0000,16'h0000,8'd0};
    tv[2]  = '{1'b0,1'b0,3'd0,16'h0000,3'd3,3'd5,16'h0000,16'h0000,8'd0};
    tv[3]  = '{1'b0,1'b0,3'd0,16'h0000,3'd4,3'd0,16'h0000,16'h0000,8'd0};
    tv[4]  = '{1'b1,1'b1,3'd3,16'hBEEF,3'd1,3'd2,16'h0000,16'h0000,8'd0};
    tv[5]  = '{1'b1,1'b0,3'd0,16'h0000,3'd3,3'd3,16'hBEEF,16'hBEEF,8'd1};
    tv[6]  = '{1'b1,1'b1,3'd5,16'h1234,3'd5,3'd3,16'h1234,16'hBEEF,8'd1};
    tv[7]  = '{1'b1,1'b0,3'd0,16'h0000,3'd5,3'd5,16'h1234,16'h1234,8'd2};
    tv[8]  = '{1'b1,1'b1,3'd0,16'hFFFF,3'd0,3'd0,16'h0000,16'h0000,8'd2};
    tv[9]  = '{1'b1,1'b0,3'd0,16'h0000,3'd0,3'd5,16'h0000,16'h1234,8'd2};
    tv[10] = '{1'b0,1'b1,3'd2,16'hAAAA,3'd2,3'd2,16'h0000,16'h0000,8'd2};
    tv[11] = '{1'b1,1'b1,3'd2,16'hAAAA,3'd2,3'd3,16'hAAAA,16'hBEEF,8'd2};
    tv[12] = '{1'b1,1'b0,3'd0,16'h0000,3'd2,3'd2,16'hAAAA,16'hAAAA,8'd3};
    tv[13] = '{1'b1,1'b0,3'd2,16'h0000,3'd2,3'd1,16'hAAAA,16'h0000,8'd3};
    tv[14] = '{1'b1,1'b0,3'd0,16'h0000,3'd2,3'd0,16'hAAAA,16'h0000,8'd3};
    tv[15] = '{1'b1,1'b1,3'd6,16'h0F0F,3'd6,3'd6,16'h0F0F,16'h0F0F,8'd3};
    tv[16] = '{1'b1,1'b0,3'd0,16'h0000,3'd6,3'd7,16'h0F0F,16'h0000,8'd4};

    drive(1'b1, 1'b1, 1'b1, 3'd4, 16'h5555, 3'd7, 3'd4);
    tick();
    drive(1'b1, 1'b1, 1'b1, 3'd4, 16'h5555, 3'd7, 3'd4);
    check("rst_hold_rd1", RD1, 16'h0000);
    check("rst_hold_rd2", RD2, 16'h0000);
    check("rst_hold_cnt", {8'h00, WR_CNT}, 16'h0000);
    tick();

    for (int i = 0; i < 17; i++) begin
      drive(1'b0, tv[i].e, tv[i].we, tv[i].wa, tv[i].wd, tv[i].ra1, tv[i].ra2);
      check($sformatf("vec%0d_rd1", i), RD1, tv[i].x1);
      check($sformatf("vec%0d_rd2", i), RD2, tv[i].x2);
      check($sformatf("vec%0d_cnt", i), {8'h00, WR_CNT}, {8'h00, tv[i].xc});
      tick();
    end

    // WA/WD floating while WE is low must leave state alone.
    drive(1'b0, 1'b1, 1'b0, 3'bxxx, 16'hxxxx, 3'd2, 3'd3);
    tick();
    drive(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd3);
    check("xz_rd1", RD1, 16'hAAAA);
    check("xz_rd2", RD2, 16'hBEEF);
    check("xz_cnt", {8'h00, WR_CNT}, 16'h0004);

    for (int r = 1; r < 8; r++) begin
      drive(1'b0, 1'b1, 1'b1, 3'(r), 16'h1111 * 16'(r), 3'd0, 3'd0);
      tick();
    end
    for (int r = 1; r < 8; r++) begin
      drive(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'(r), 3'(8 - r));
      check($sformatf("load_r%0d", r), RD1, 16'h1111 * 16'(r));
      check($sformatf("load_r%0d_p2", 8 - r), RD2, 16'h1111 * 16'(8 - r));
    end
    check("load_cnt", {8'h00, WR_CNT}, 16'h000B);

    // Reset with a write to R4 presented: no bypass, old contents still visible.
    drive(1'b1, 1'b1, 1'b1, 3'd4, 16'h5555, 3'd4, 3'd1);
    check("rst_nobyp_rd1", RD1, 16'h4444);
    check("rst_nobyp_rd2", RD2, 16'h1111);
    tick();
    for (int r = 0; r < 8; r++) begin
      drive(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'(r), 3'(7 - r));
      check($sformatf("post_rst_r%0d", r), RD1, 16'h0000);
      check($sformatf("post_rst_p2_r%0d", 7 - r), RD2, 16'h0000);
    end
    check("post_rst_cnt", {8'h00, WR_CNT}, 16'h0000);

    drive(1'b0, 1'b1, 1'b1, 3'd1, 16'h7777, 3'd1, 3'd4);
    check("first_wr_byp", RD1, 16'h7777);
    check("first_wr_r4", RD2, 16'h0000);
    tick();
    drive(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd1);
    check("first_wr_r1", RD1, 16'h7777);
    check("first_wr_cnt", {8'h00, WR_CNT}, 16'h0001);

    for (int i = 1; i < 256; i++) begin
      drive(1'b0, 1'b1, 1'b1, 3'((i % 7) + 1), 16'(i), 3'd0, 3'd0);
      if (i == 255) check("cnt_pre_wrap", {8'h00, WR_CNT}, 16'h00FF);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd3);
    check("cnt_wrap", {8'h00, WR_CNT}, 16'h0000);
    check("wrap_r4", RD1, 16'h00FF);
    check("wrap_r3", RD2, 16'h00FE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
